// File: rtl/muldiv_if.sv
// muldiv_if: core-side bundle for the multiply/divide unit
interface muldiv_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  modport master (output start, op, rs_data, rt_data, hi_we, lo_we, wdata, input busy, done, hi, lo);
  modport slave (input start, op, rs_data, rt_data, hi_we, lo_we, wdata, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-cycle multiply/divide with architectural HI/LO
module muldiv_unit (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state, state_nx;
  logic [31:0] acc, mq, dvs, src, hi_reg, lo_reg;
  logic [4:0] cnt;
  logic is_div, neg_q, neg_r, done_reg;
  logic sgn, a_neg, b_neg, ge;
  logic [32:0] add;
  logic [31:0] diff, quo, rem;
  logic [63:0] prod, prod_s;
  assign sgn = ~bus.op[0];
  assign a_neg = sgn & bus.rs_data[31];
  assign b_neg = sgn & bus.rt_data[31];
  // {acc,mq} holds the running product (multiply) or remainder/quotient (divide)
  assign add = {1'b0, acc} + {1'b0, mq[0] ? dvs : 32'd0};
  assign ge = {acc, mq[31]} >= {1'b0, dvs};
  // The true difference is below the divisor when ge, so 32-bit wraparound is exact
  assign diff = {acc[30:0], mq[31]} - dvs;
  assign prod = {acc, mq};
  assign prod_s = neg_q ? -prod : prod;
  assign quo = dvs == 32'd0 ? 32'hFFFF_FFFF : neg_q ? -mq : mq;
  assign rem = dvs == 32'd0 ? src : neg_r ? -acc : acc;
  assign bus.busy = state != IDLE;
  assign bus.done = done_reg;
  assign bus.hi = hi_reg;
  assign bus.lo = lo_reg;
  // State register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  // Next-state: launch on start, iterate until cnt reaches zero, one fix-up cycle
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (bus.start ? CALC : IDLE) : state == CALC ? (cnt == 5'd0 ? FIX : CALC) : IDLE;
  end
  // Datapath: operand capture, per-cycle iteration, sign fix-up and MTHI/MTLO
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      acc <= '0;
      mq <= '0;
      dvs <= '0;
      src <= '0;
      cnt <= '0;
      is_div <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      hi_reg <= '0;
      lo_reg <= '0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= state == FIX;
      if (state == IDLE) begin
        if (bus.start) begin
          acc <= '0;
          mq <= a_neg ? -bus.rs_data : bus.rs_data;
          dvs <= b_neg ? -bus.rt_data : bus.rt_data;
          src <= bus.rs_data;
          is_div <= bus.op[1];
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
          cnt <= 5'd31;
        end else begin
          if (bus.hi_we) hi_reg <= bus.wdata;
          if (bus.lo_we) lo_reg <= bus.wdata;
        end
      end else if (state == CALC) begin
        cnt <= cnt == 5'd0 ? cnt : cnt - 5'd1;
        if (is_div) begin
          acc <= ge ? diff : {acc[30:0], mq[31]};
          mq <= {mq[30:0], ge};
        end else begin
          {acc, mq} <= {add, mq[31:1]};
        end
      end else begin
        hi_reg <= is_div ? rem : prod_s[63:32];
        lo_reg <= is_div ? quo : prod_s[31:0];
      end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed plus random checks of muldiv_unit against an arithmetic model
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  muldiv_if bus();
  muldiv_unit dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [63:0] exp_r = '0;

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    int q, r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (o)
      2'b00: return sa * sb;
      2'b01: return {32'd0, a} * {32'd0, b};
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op = o;
    bus.rs_data = a;
    bus.rt_data = b;
    exp_r = model(o, a, b);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.rs_data = $urandom;
    bus.rt_data = $urandom;
  endtask

  task automatic finish(input string tag, input int pre);
    int n = pre;
    @(negedge clk);
    while (bus.busy && n < 100) begin
      chk({tag, "_hold_hi"}, bus.hi, m_hi);
      chk({tag, "_hold_lo"}, bus.lo, m_lo);
      chk({tag, "_early_done"}, {31'd0, bus.done}, 32'd0);
      n++;
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, 32'(n), 32'd33);
    m_hi = exp_r[63:32];
    m_lo = exp_r[31:0];
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd1);
    chk({tag, "_hi"}, bus.hi, m_hi);
    chk({tag, "_lo"}, bus.lo, m_lo);
    @(negedge clk);
    chk({tag, "_done_drop"}, {31'd0, bus.done}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    launch(o, a, b);
    finish(tag, 0);
  endtask

  initial begin
    int pulses;
    logic [31:0] a, b;
    logic [1:0] o;
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.rs_data = '0;
    bus.rt_data = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_done", {31'd0, bus.done}, 32'd0);
    chk("reset_hi", bus.hi, 32'd0);
    chk("reset_lo", bus.lo, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    run_op("mult_neg3x5", 2'b00, 32'hFFFF_FFFD, 32'd5);
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div_neg7by2", 2'b10, 32'hFFFF_FFF9, 32'd2);
    run_op("divu_100by7", 2'b11, 32'd100, 32'd7);
    run_op("divu_by0", 2'b11, 32'h1234, 32'd0);
    run_op("div_min_by_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_by0", 2'b10, 32'hFFFF_FF00, 32'd0);
    bus.hi_we = 1'b1;
    bus.wdata = 32'hAAAA_0000;
    @(posedge clk);
    #1 bus.hi_we = 1'b0;
    m_hi = 32'hAAAA_0000;
    @(negedge clk);
    chk("mthi_hi", bus.hi, m_hi);
    chk("mthi_lo", bus.lo, m_lo);
    bus.lo_we = 1'b1;
    bus.wdata = 32'h0000_5555;
    @(posedge clk);
    #1 bus.lo_we = 1'b0;
    m_lo = 32'h0000_5555;
    @(negedge clk);
    chk("mtlo_lo", bus.lo, m_lo);
    chk("mtlo_hi", bus.hi, m_hi);
    launch(2'b11, 32'd100, 32'd7);
    repeat (3) begin
      @(negedge clk);
      bus.hi_we = 1'b1;
      bus.lo_we = 1'b1;
      bus.wdata = $urandom;
    end
    @(negedge clk);
    chk("hi_we_busy", bus.hi, m_hi);
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    finish("busy_write", 4);
    bus.hi_we = 1'b1;
    bus.wdata = 32'h1234_5678;
    launch(2'b01, 32'd3, 32'd4);
    bus.hi_we = 1'b0;
    finish("start_wins", 0);
    launch(2'b00, 32'h0001_0000, 32'hFFFF_0003);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    m_hi = '0;
    m_lo = '0;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    chk("abort_hi", bus.hi, 32'd0);
    chk("abort_lo", bus.lo, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    chk("abort_no_done", 32'(pulses), 32'd0);
    chk("abort_hi_held", bus.hi, 32'd0);
    run_op("after_abort_divu", 2'b11, 32'd100, 32'd7);
    for (int i = 0; i < 20; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'd1;
        2: b = 32'hFFFF_FFFF;
        3: b = $urandom_range(1, 20);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      run_op("rand", o, a, b);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
